// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel allocator's memory interface.
package falafel_pkg;

  localparam int DATA_W     = 32;
  localparam int BYTE_OFF_W = $clog2(DATA_W / 8);

  typedef struct packed {
    logic              is_write;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/falafel_mem_responder_if.sv
// Request/response handshake bundle between the falafel allocator (master)
// and its memory responder (slave).
interface falafel_mem_responder_if;
  import falafel_pkg::*;

  logic              mem_req_val;
  logic              mem_req_rdy;
  logic              mem_req_is_write;
  logic [DATA_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_resp_val;
  logic              mem_resp_rdy;
  logic [DATA_W-1:0] mem_resp_data;

  modport master (
    output mem_req_val, mem_req_is_write, mem_req_addr, mem_req_data, mem_resp_rdy,
    input  mem_req_rdy, mem_resp_val, mem_resp_data
  );

  modport slave (
    input  mem_req_val, mem_req_is_write, mem_req_addr, mem_req_data, mem_resp_rdy,
    output mem_req_rdy, mem_resp_val, mem_resp_data
  );

endinterface

// File: rtl/falafel_fifo.sv
// Small synchronous FIFO with extra-MSB pointers for full/empty detection.
// The head word is read straight out of the register file, so it is stable
// for as long as it is not popped.
module falafel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = store[rd_ptr[AW-1:0]];

  // Pointer advance and storage write; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        store[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr                <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/falafel_mem_responder.sv
// Memory-side responder: word array, fixed-latency response pipeline and an
// in-order response queue guarded by credit counting so it can never overflow.
module falafel_mem_responder
  import falafel_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  falafel_mem_responder_if.slave  mem
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RESP_DEPTH) + 1;

  if (LATENCY < 1) begin : g_bad_latency
    $error("falafel_mem_responder: LATENCY must be at least 1");
  end
  if (LATENCY > RESP_DEPTH) begin : g_bad_depth
    $error("falafel_mem_responder: LATENCY must not exceed RESP_DEPTH");
  end

  mem_req_t          req;
  mem_resp_t         resp_word;
  mem_resp_t         push_word;
  mem_resp_t         head_word;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] array [DEPTH];
  logic [CNT_W-1:0]  outstanding;
  logic              accept;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              unused_addr_bits;

  assign req = '{is_write: mem.mem_req_is_write,
                 addr:     mem.mem_req_addr,
                 data:     mem.mem_req_data};

  // Byte-offset bits and bits above the array size are deliberately ignored (aliasing).
  assign idx              = req.addr[BYTE_OFF_W +: IDX_W];
  assign unused_addr_bits = ^{req.addr[DATA_W-1:BYTE_OFF_W+IDX_W], req.addr[BYTE_OFF_W-1:0]};

  // Credits come from the registered count only, so rdy never depends on req_val.
  assign mem.mem_req_rdy = !rst_i && (outstanding < CNT_W'(RESP_DEPTH));
  assign accept          = mem.mem_req_val && mem.mem_req_rdy;

  assign mem.mem_resp_val  = !rst_i && !fifo_empty;
  assign mem.mem_resp_data = rst_i ? '0 : head_word.data;
  assign pop               = mem.mem_resp_val && mem.mem_resp_rdy;

  // Writes echo their data; reads see the array as it stood before this edge.
  assign resp_word = '{data: (req.is_write ? req.data : array[idx])};

  // Word array update on accepted writes; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && req.is_write) begin
      array[idx] <= req.data;
    end
  end

  if (LATENCY == 1) begin : g_no_delay
    assign push      = accept;
    assign push_word = resp_word;
  end else begin : g_delay
    logic      stage_val  [LATENCY-1];
    mem_resp_t stage_word [LATENCY-1];

    // Valid shift chain; cleared on reset so in-flight responses are dropped.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < LATENCY - 1; i++) begin
          stage_val[i] <= 1'b0;
        end
      end else begin
        stage_val[0] <= accept;
        for (int i = 1; i < LATENCY - 1; i++) begin
          stage_val[i] <= stage_val[i-1];
        end
      end
    end

    // Data shift chain; only meaningful where the matching valid is set.
    always_ff @(posedge clk_i) begin
      stage_word[0] <= resp_word;
      for (int i = 1; i < LATENCY - 1; i++) begin
        stage_word[i] <= stage_word[i-1];
      end
    end

    assign push      = stage_val[LATENCY-2];
    assign push_word = stage_word[LATENCY-2];
  end

  falafel_fifo #(
    .WIDTH ($bits(mem_resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_q (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outstanding responses = pipeline + queue; simultaneous accept and pop cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  a_outstanding_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding <= CNT_W'(RESP_DEPTH));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_full));

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Directed bench for falafel_mem_responder: reset, write/read, backpressure,
// streaming, aliasing and mid-flight reset, with an in-order response scoreboard.
module tb_falafel_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  falafel_mem_responder_if bus ();

  falafel_mem_responder #(
    .DEPTH      (1024),
    .LATENCY    (2),
    .RESP_DEPTH (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mem   (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        lat_check = 1'b0;
  logic        last_acc = 1'b0;
  logic [31:0] last_pop = '0;
  logic [31:0] exp_q [$];
  int          acc_q [$];
  logic [31:0] ref_mem [int];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, keeps the scoreboard at mid-cycle, returns just after the next edge.
  task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic rr);
    logic [31:0] exp_v;
    int          t;
    int          idx;
    bus.mem_req_val      = v;
    bus.mem_req_is_write = w;
    bus.mem_req_addr     = a;
    bus.mem_req_data     = d;
    bus.mem_resp_rdy     = rr;
    @(negedge clk);
    last_acc = bus.mem_req_val && bus.mem_req_rdy;
    if (bus.mem_resp_val && bus.mem_resp_rdy) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected resp", {31'b0, bus.mem_resp_val}, 32'd0);
      end else begin
        exp_v = exp_q.pop_front();
        t     = acc_q.pop_front();
        checkOutput("resp data", bus.mem_resp_data, exp_v);
        if (lat_check) checkOutput("resp latency", cyc - t, 32'd2);
        last_pop = bus.mem_resp_data;
      end
    end else if (bus.mem_resp_val && exp_q.size() > 0) begin
      checkOutput("held data", bus.mem_resp_data, exp_q[0]);
    end
    if (last_acc) begin
      idx = int'((a >> 2) & 32'h3ff);
      if (w) begin
        ref_mem[idx] = d;
        exp_q.push_back(d);
      end else begin
        exp_q.push_back(ref_mem.exists(idx) ? ref_mem[idx] : 32'hxxxx_xxxx);
      end
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sendReq(input logic w, input logic [31:0] a, input logic [31:0] d);
    int tries = 0;
    do begin
      applyStimulus(1'b1, w, a, d, 1'b1);
      tries++;
    end while (!last_acc && tries < 20);
    checkOutput("req accepted", {31'b0, last_acc}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      n++;
    end
    checkOutput("drain left", exp_q.size(), 32'd0);
  endtask

  initial begin
    int nxt;
    bus.mem_req_val      = 1'b1;
    bus.mem_req_is_write = 1'b0;
    bus.mem_req_addr     = '0;
    bus.mem_req_data     = '0;
    bus.mem_resp_rdy     = 1'b0;

    $display("[TB] reset with req_val high");
    #1;
    checkOutput("reset rdy c0", {31'b0, bus.mem_req_rdy}, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("reset rdy", {31'b0, bus.mem_req_rdy}, 32'd0);
      checkOutput("reset resp_val", {31'b0, bus.mem_resp_val}, 32'd0);
      checkOutput("reset resp_data", bus.mem_resp_data, 32'd0);
    end
    rst              = 1'b0;
    bus.mem_req_val  = 1'b0;
    #1;
    checkOutput("rdy after reset", {31'b0, bus.mem_req_rdy}, 32'd1);

    $display("[TB] write then read");
    lat_check = 1'b1;
    sendReq(1'b1, 32'h40, 32'hCAFE_F00D);
    sendReq(1'b0, 32'h40, 32'd0);
    sendReq(1'b0, 32'h42, 32'd0);
    drain();
    checkOutput("read offset 0x42", last_pop, 32'hCAFE_F00D);

    $display("[TB] backpressure");
    for (int k = 0; k < 6; k++) sendReq(1'b1, 32'h200 + 32'(k * 4), 32'hB000_0000 + 32'(k));
    drain();
    lat_check = 1'b0;
    nxt = 0;
    repeat (6) begin
      applyStimulus(1'b1, 1'b0, 32'h200 + 32'(nxt * 4), 32'd0, 1'b0);
      if (last_acc) nxt++;
    end
    checkOutput("bp accepted", nxt, 32'd4);
    checkOutput("bp rdy low", {31'b0, bus.mem_req_rdy}, 32'd0);
    checkOutput("bp resp_val", {31'b0, bus.mem_resp_val}, 32'd1);
    for (int g = 0; g < 30 && nxt < 6; g++) begin
      applyStimulus(1'b1, 1'b0, 32'h200 + 32'(nxt * 4), 32'd0, 1'b1);
      if (last_acc) nxt++;
    end
    checkOutput("bp all accepted", nxt, 32'd6);
    drain();
    checkOutput("bp last read", last_pop, 32'hB000_0005);

    $display("[TB] streaming");
    for (int k = 0; k < 8; k++) sendReq(1'b1, 32'(k * 4), 32'hA0 + 32'(k));
    drain();
    lat_check = 1'b1;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, (i % 3) != 1, 32'(((i * 5) % 8) * 4 + (i % 4)), 32'h5000_0000 + 32'(i), 1'b1);
      checkOutput("stream accept", {31'b0, last_acc}, 32'd1);
    end
    drain();

    $display("[TB] alias");
    sendReq(1'b1, 32'h0, 32'h1);
    sendReq(1'b0, 32'h1000, 32'd0);
    drain();
    checkOutput("alias read", last_pop, 32'h1);

    $display("[TB] mid-flight reset");
    sendReq(1'b1, 32'h300, 32'h600D_DA7A);
    drain();
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h300, 32'd0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    repeat (5) begin
      checkOutput("post reset resp_val", {31'b0, bus.mem_resp_val}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    sendReq(1'b0, 32'h300, 32'd0);
    drain();
    checkOutput("retained after reset", last_pop, 32'h600D_DA7A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
